// File: rtl/ex_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU ops, mul/div ops and FSM states.
package ex_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        MdMul   = 2'b00,
        MdMulhu = 2'b01,
        MdDivu  = 2'b10,
        MdRemu  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } ex_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; undefined op codes produce zero.
module alu
    import ex_pkg::*;
#(
    parameter int unsigned BIT_W = 32
) (
    input  logic [BIT_W-1:0] a_i,
    input  logic [BIT_W-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [BIT_W-1:0] res_o
);

    localparam int unsigned ShW = $clog2(BIT_W);

    logic [ShW-1:0] shamt;
    assign shamt = b_i[ShW-1:0];

    always_comb begin
        res_o = '0;
        case (op_i)
            AluAdd:   res_o = a_i + b_i;
            AluSub:   res_o = a_i - b_i;
            AluSll:   res_o = a_i << shamt;
            AluSlt:   res_o = {{(BIT_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            AluSltu:  res_o = {{(BIT_W-1){1'b0}}, a_i < b_i};
            AluXor:   res_o = a_i ^ b_i;
            AluSrl:   res_o = a_i >> shamt;
            AluSra:   res_o = $unsigned($signed(a_i) >>> shamt);
            AluOr:    res_o = a_i | b_i;
            AluAnd:   res_o = a_i & b_i;
            AluPassB: res_o = b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned multiplier (shift-add) and restoring divider sharing one
// 2*BIT_W accumulator: {hi, lo} = {partial product | remainder, multiplier | quotient}.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int unsigned BIT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [BIT_W-1:0] a_i,
    input  logic [BIT_W-1:0] b_i,
    output logic             done_o,
    output logic [BIT_W-1:0] result_o
);

    localparam int unsigned CntW = $clog2(BIT_W);
    localparam logic [CntW-1:0] CntLast = CntW'(BIT_W - 1);

    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [1:0]         op_q, op_d;
    logic [BIT_W-1:0]   b_q, b_d;
    logic [2*BIT_W-1:0] acc_q, acc_d;
    logic [BIT_W:0]     add_sum, div_diff;

    assign add_sum  = {1'b0, acc_q[2*BIT_W-1:BIT_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign div_diff = acc_q[2*BIT_W-1:BIT_W-1] - {1'b0, b_q};

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        op_d  = op_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
            op_d  = op_i;
            b_d   = b_i;
            acc_d = {{BIT_W{1'b0}}, a_i};
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
                run_d = 1'b0;
            end
            if (op_q[1]) begin
                // Zero divisor always subtracts: quotient all ones, remainder = dividend.
                if (!div_diff[BIT_W]) begin
                    acc_d = {div_diff[BIT_W-1:0], acc_q[BIT_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*BIT_W-2:0], 1'b0};
                end
            end else begin
                acc_d = {add_sum, acc_q[BIT_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
            op_q  <= op_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign done_o = run_q && (cnt_q == CntLast);

    // MULHU and REMU take the high half, MUL and DIVU the low half.
    assign result_o = op_q[0] ? acc_q[2*BIT_W-1:BIT_W] : acc_q[BIT_W-1:0];

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage with single-cycle ALU path, branch/jump resolution and an iterative
// mul/div unit that holds issue while it runs.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int unsigned BIT_W = 32,
    parameter bit          MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIT_W-1:0] pc_in,
    input  logic [BIT_W-1:0] rs1_dat,
    input  logic [BIT_W-1:0] rs2_dat,
    input  logic [BIT_W-1:0] imm,
    input  logic             alusrc,
    input  logic             jal,
    input  logic             jalr,
    input  logic             branch,
    input  logic             bne,
    input  logic             branch_taken,
    input  logic             compressed,
    input  logic [3:0]       aluctrl,
    input  logic             md_valid,
    input  logic [1:0]       md_op,
    input  logic [4:0]       rd_in,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             mem2reg_in,
    input  logic             regwr_in,
    input  logic             fwd_a_flag,
    input  logic [BIT_W-1:0] fwd_a_dat,
    input  logic             fwd_b_flag,
    input  logic [BIT_W-1:0] fwd_b_dat,
    input  logic             stall,
    output logic             out_valid,
    output logic [BIT_W-1:0] alu_result,
    output logic [BIT_W-1:0] mem_wdata,
    output logic [BIT_W-1:0] pc_step,
    output logic [4:0]       rd_out,
    output logic             memrd_out,
    output logic             memwr_out,
    output logic             mem2reg_out,
    output logic             regwr_out,
    output logic             jump_out,
    output logic             redirect,
    output logic [BIT_W-1:0] redirect_pc,
    output logic             feedback_valid,
    output logic             busy
);

    typedef struct packed {
        logic             valid;
        logic [BIT_W-1:0] alu;
        logic [BIT_W-1:0] wdata;
        logic [BIT_W-1:0] pc_step;
        logic [4:0]       rd;
        logic             memrd;
        logic             memwr;
        logic             mem2reg;
        logic             regwr;
        logic             jump;
    } payload_t;

    ex_state_e        state_q, state_d;
    payload_t         pay_q, pay_d, md_q, md_d, cur;
    logic [BIT_W-1:0] rs1, rs2, op_a, op_b, alu_out, pc_next, md_result;
    logic             accept, md_start, md_done, taken;

    assign rs1  = fwd_a_flag ? fwd_a_dat : rs1_dat;
    assign rs2  = fwd_b_flag ? fwd_b_dat : rs2_dat;
    assign op_a = (jal || branch) ? pc_in : rs1;
    assign op_b = alusrc ? imm : rs2;

    assign pc_next  = pc_in + (compressed ? BIT_W'(2) : BIT_W'(4));
    assign in_ready = !stall && (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && md_valid && MD_EN;
    assign busy     = (state_q != StIdle);

    alu #(
        .BIT_W(BIT_W)
    ) u_alu (
        .a_i  (op_a),
        .b_i  (op_b),
        .op_i (aluctrl),
        .res_o(alu_out)
    );

    muldiv_iter #(
        .BIT_W(BIT_W)
    ) u_muldiv (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (md_start),
        .op_i    (md_op),
        .a_i     (rs1),
        .b_i     (rs2),
        .done_o  (md_done),
        .result_o(md_result)
    );

    assign taken          = (rs1 == rs2) ^ bne;
    assign feedback_valid = accept && branch;
    assign redirect       = accept && ((branch && (taken != branch_taken)) || jal || jalr);

    always_comb begin
        redirect_pc = alu_out;
        if (jalr) begin
            redirect_pc = {alu_out[BIT_W-1:1], 1'b0};
        end else if (branch && !taken) begin
            redirect_pc = pc_next;
        end
    end

    always_comb begin
        cur         = '0;
        cur.valid   = 1'b1;
        cur.alu     = alu_out;
        cur.wdata   = rs2;
        cur.pc_step = pc_next;
        cur.rd      = rd_in;
        cur.memrd   = memrd_in;
        cur.memwr   = memwr_in;
        cur.mem2reg = mem2reg_in;
        cur.regwr   = regwr_in;
        cur.jump    = jal || jalr;
    end

    always_comb begin
        state_d = state_q;
        pay_d   = pay_q;
        md_d    = md_q;
        unique case (state_q)
            StIdle: begin
                if (md_start) begin
                    state_d = StBusy;
                    md_d      = cur;
                    md_d.jump = 1'b0;
                end
            end
            StBusy: if (md_done) state_d = StDone;
            StDone: if (!stall) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Payload only moves when downstream is not holding.
        if (!stall) begin
            pay_d.valid = 1'b0;
            pay_d.regwr = 1'b0;
            pay_d.memwr = 1'b0;
            pay_d.memrd = 1'b0;
            pay_d.jump  = 1'b0;
            if (state_q == StDone) begin
                pay_d     = md_q;
                pay_d.alu = md_result;
            end else if (accept && !md_start) begin
                pay_d = cur;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pay_q   <= '0;
            md_q    <= '0;
        end else begin
            state_q <= state_d;
            pay_q   <= pay_d;
            md_q    <= md_d;
        end
    end

    assign out_valid   = pay_q.valid;
    assign alu_result  = pay_q.alu;
    assign mem_wdata   = pay_q.wdata;
    assign pc_step     = pay_q.pc_step;
    assign rd_out      = pay_q.rd;
    assign memrd_out   = pay_q.memrd;
    assign memwr_out   = pay_q.memwr;
    assign mem2reg_out = pay_q.mem2reg;
    assign regwr_out   = pay_q.regwr;
    assign jump_out    = pay_q.jump;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomized bench for ex_stage_mc against a transaction-level model of the stage.
module tb_ex_stage_mc;
    import ex_pkg::*;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  pc_in, rs1_dat, rs2_dat, imm;
    logic          alusrc, jal, jalr, branch, bne, branch_taken, compressed;
    logic [3:0]    aluctrl;
    logic          md_valid;
    logic [1:0]    md_op;
    logic [4:0]    rd_in;
    logic          memrd_in, memwr_in, mem2reg_in, regwr_in;
    logic          fwd_a_flag, fwd_b_flag;
    logic [W-1:0]  fwd_a_dat, fwd_b_dat;
    logic          stall;
    logic          out_valid;
    logic [W-1:0]  alu_result, mem_wdata, pc_step;
    logic [4:0]    rd_out;
    logic          memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out;
    logic          redirect, feedback_valid, busy;
    logic [W-1:0]  redirect_pc;

    int checks   = 0;
    int failures = 0;

    // Model of the registered EX/MEM payload.
    logic         m_valid, m_memrd, m_memwr, m_mem2reg, m_regwr, m_jump;
    logic [W-1:0] m_alu, m_wdata, m_pcstep;
    logic [4:0]   m_rd;

    ex_stage_mc #(
        .BIT_W(W),
        .MD_EN(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc_in         (pc_in),
        .rs1_dat       (rs1_dat),
        .rs2_dat       (rs2_dat),
        .imm           (imm),
        .alusrc        (alusrc),
        .jal           (jal),
        .jalr          (jalr),
        .branch        (branch),
        .bne           (bne),
        .branch_taken  (branch_taken),
        .compressed    (compressed),
        .aluctrl       (aluctrl),
        .md_valid      (md_valid),
        .md_op         (md_op),
        .rd_in         (rd_in),
        .memrd_in      (memrd_in),
        .memwr_in      (memwr_in),
        .mem2reg_in    (mem2reg_in),
        .regwr_in      (regwr_in),
        .fwd_a_flag    (fwd_a_flag),
        .fwd_a_dat     (fwd_a_dat),
        .fwd_b_flag    (fwd_b_flag),
        .fwd_b_dat     (fwd_b_dat),
        .stall         (stall),
        .out_valid     (out_valid),
        .alu_result    (alu_result),
        .mem_wdata     (mem_wdata),
        .pc_step       (pc_step),
        .rd_out        (rd_out),
        .memrd_out     (memrd_out),
        .memwr_out     (memwr_out),
        .mem2reg_out   (mem2reg_out),
        .regwr_out     (regwr_out),
        .jump_out      (jump_out),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .feedback_valid(feedback_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            AluAdd:   return a + b;
            AluSub:   return a - b;
            AluSll:   return a << b[4:0];
            AluSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            AluSltu:  return (a < b) ? 32'd1 : 32'd0;
            AluXor:   return a ^ b;
            AluSrl:   return a >> b[4:0];
            AluSra:   return 32'($signed(a) >>> b[4:0]);
            AluOr:    return a | b;
            AluAnd:   return a & b;
            AluPassB: return b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] md_ref(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic model_zero();
        m_valid = 0; m_memrd = 0; m_memwr = 0; m_mem2reg = 0; m_regwr = 0; m_jump = 0;
        m_alu = 0; m_wdata = 0; m_pcstep = 0; m_rd = 0;
    endtask

    task automatic model_bubble();
        m_valid = 0; m_regwr = 0; m_memwr = 0; m_memrd = 0; m_jump = 0;
    endtask

    task automatic check_payload(string tag);
        check({tag, ".valid"}, out_valid, m_valid);
        check({tag, ".alu"}, alu_result, m_alu);
        check({tag, ".wdata"}, mem_wdata, m_wdata);
        check({tag, ".pcstep"}, pc_step, m_pcstep);
        check({tag, ".rd"}, rd_out, m_rd);
        check({tag, ".memrd"}, memrd_out, m_memrd);
        check({tag, ".memwr"}, memwr_out, m_memwr);
        check({tag, ".mem2reg"}, mem2reg_out, m_mem2reg);
        check({tag, ".regwr"}, regwr_out, m_regwr);
        check({tag, ".jump"}, jump_out, m_jump);
    endtask

    task automatic rand_fields();
        int kind;
        pc_in        = $urandom & 32'hFFFF_FFFE;
        rs1_dat      = $urandom;
        rs2_dat      = $urandom;
        imm          = $urandom;
        fwd_a_flag   = 1'($urandom);
        fwd_a_dat    = $urandom;
        fwd_b_flag   = 1'($urandom);
        fwd_b_dat    = $urandom;
        alusrc       = 1'($urandom);
        aluctrl      = 4'($urandom_range(0, 11));
        kind         = $urandom_range(0, 4);
        branch       = (kind == 1) || (kind == 2);
        jal          = (kind == 3);
        jalr         = (kind == 4);
        if (kind == 2) begin
            rs2_dat    = rs1_dat;
            fwd_b_flag = fwd_a_flag;
            fwd_b_dat  = fwd_a_dat;
        end
        bne          = 1'($urandom);
        branch_taken = 1'($urandom);
        compressed   = 1'($urandom);
        md_valid     = 1'($urandom);
        md_op        = 2'($urandom);
        rd_in        = 5'($urandom);
        memrd_in     = 1'($urandom);
        memwr_in     = 1'($urandom);
        mem2reg_in   = 1'($urandom);
        regwr_in     = 1'($urandom);
    endtask

    // Caller has driven this cycle's fields at the falling edge with md_valid = 0.
    task automatic run_alu(string tag);
        logic [W-1:0] a, b, oa, ob, res, pcs, rpc;
        logic         tk, rdr;
        in_valid = 1'b1;
        stall    = 1'b0;
        #1;
        a   = fwd_a_flag ? fwd_a_dat : rs1_dat;
        b   = fwd_b_flag ? fwd_b_dat : rs2_dat;
        oa  = (jal || branch) ? pc_in : a;
        ob  = alusrc ? imm : b;
        res = alu_ref(aluctrl, oa, ob);
        pcs = pc_in + (compressed ? 32'd2 : 32'd4);
        tk  = (a == b) != bne;
        rdr = (branch && (tk != branch_taken)) || jal || jalr;
        rpc = jalr ? (res & ~32'd1) : (branch && !tk) ? pcs : res;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        check({tag, ".redirect"}, redirect, rdr);
        check({tag, ".feedback"}, feedback_valid, branch);
        check({tag, ".redirect_pc"}, redirect_pc, rpc);
        @(posedge clk);
        #1;
        m_valid = 1; m_alu = res; m_wdata = b; m_pcstep = pcs; m_rd = rd_in;
        m_memrd = memrd_in; m_memwr = memwr_in; m_mem2reg = mem2reg_in; m_regwr = regwr_in;
        m_jump = jal || jalr;
        check_payload(tag);
    endtask

    task automatic bubble_cycle(string tag);
        @(negedge clk);
        rand_fields();
        in_valid = 1'b0;
        stall    = 1'b0;
        #1;
        check({tag, ".redirect"}, redirect, 1'b0);
        check({tag, ".feedback"}, feedback_valid, 1'b0);
        @(posedge clk);
        #1;
        model_bubble();
        check_payload(tag);
    endtask

    task automatic stall_cycle(string tag);
        @(negedge clk);
        rand_fields();
        in_valid = 1'b1;
        stall    = 1'b1;
        #1;
        check({tag, ".in_ready"}, in_ready, 1'b0);
        check({tag, ".redirect"}, redirect, 1'b0);
        @(posedge clk);
        #1;
        check_payload(tag);
    endtask

    task automatic run_md(string tag, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                          int n_done_stall, bit stall_busy, int rst_at);
        logic [W-1:0] e_pcs;
        logic [4:0]   e_rd;
        logic         e_memrd, e_memwr, e_mem2reg, e_regwr;
        @(negedge clk);
        rand_fields();
        branch = 0; jal = 0; jalr = 0;
        if (fwd_a_flag) fwd_a_dat = a; else rs1_dat = a;
        if (fwd_b_flag) fwd_b_dat = b; else rs2_dat = b;
        md_valid = 1'b1;
        md_op    = op;
        in_valid = 1'b1;
        stall    = 1'b0;
        #1;
        check({tag, ".accept_ready"}, in_ready, 1'b1);
        check({tag, ".accept_redirect"}, redirect, 1'b0);
        e_pcs = pc_in + (compressed ? 32'd2 : 32'd4);
        e_rd = rd_in; e_memrd = memrd_in; e_memwr = memwr_in;
        e_mem2reg = mem2reg_in; e_regwr = regwr_in;
        @(posedge clk);
        #1;
        model_bubble();
        check_payload({tag, ".bubble"});
        check({tag, ".busy"}, busy, 1'b1);
        for (int k = 0; k < int'(W); k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                in_valid = 1'b0;
                stall    = 1'b0;
                #2;
                rst_n = 1'b0;
                #1;
                model_zero();
                check_payload({tag, ".rst"});
                check({tag, ".rst_busy"}, busy, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check({tag, ".rel_ready"}, in_ready, 1'b1);
                for (int j = 0; j < 40; j++) bubble_cycle({tag, ".after_rst"});
                return;
            end
            rand_fields();
            in_valid = 1'b1;
            stall    = stall_busy ? 1'($urandom) : 1'b0;
            #1;
            check({tag, ".busy_ready"}, in_ready, 1'b0);
            check({tag, ".busy_flag"}, busy, 1'b1);
            check({tag, ".busy_redirect"}, redirect, 1'b0);
            check({tag, ".busy_feedback"}, feedback_valid, 1'b0);
            @(posedge clk);
            #1;
            if (!stall) model_bubble();
            check({tag, ".busy_valid"}, out_valid, m_valid);
        end
        for (int s = 0; s < n_done_stall; s++) stall_cycle({tag, ".done_stall"});
        @(negedge clk);
        rand_fields();
        in_valid = 1'b0;
        stall    = 1'b0;
        #1;
        check({tag, ".done_ready"}, in_ready, 1'b0);
        check({tag, ".done_busy"}, busy, 1'b1);
        @(posedge clk);
        #1;
        m_valid = 1; m_alu = md_ref(op, a, b); m_wdata = b; m_pcstep = e_pcs; m_rd = e_rd;
        m_memrd = e_memrd; m_memwr = e_memwr; m_mem2reg = e_mem2reg; m_regwr = e_regwr;
        m_jump = 0;
        check_payload({tag, ".result"});
        check({tag, ".idle_busy"}, busy, 1'b0);
        bubble_cycle({tag, ".once"});
    endtask

    initial begin
        rst_n = 1'b0;
        rand_fields();
        in_valid = 1'b0;
        stall    = 1'b0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check_payload("reset");
        check("reset.busy", busy, 1'b0);
        check("reset.in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD 5 + 7
        @(negedge clk);
        rand_fields();
        branch = 0; jal = 0; jalr = 0; md_valid = 0; fwd_a_flag = 0;
        rs1_dat = 32'd5; imm = 32'd7; alusrc = 1; aluctrl = AluAdd;
        run_alu("add");
        check("add.result12", alu_result, 32'd12);

        // BEQ taken but predicted not-taken
        @(negedge clk);
        rand_fields();
        branch = 1; jal = 0; jalr = 0; bne = 0; branch_taken = 0; md_valid = 0;
        fwd_a_flag = 0; fwd_b_flag = 0; pc_in = 32'h100; rs1_dat = 3; rs2_dat = 3;
        imm = 32'h20; alusrc = 1; aluctrl = AluAdd; in_valid = 1; stall = 0;
        #1;
        check("beq.redirect", redirect, 1'b1);
        check("beq.redirect_pc", redirect_pc, 32'h120);
        check("beq.feedback", feedback_valid, 1'b1);
        run_alu("beq");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: bubble_cycle("rnd_bubble");
                1: stall_cycle("rnd_stall");
                default: ;
            endcase
            @(negedge clk);
            rand_fields();
            md_valid = 0;
            run_alu("rnd_alu");
        end

        run_md("mulhu_max", MdMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, -1);
        check("mulhu_max.const", alu_result, 32'hFFFF_FFFE);
        run_md("divu_zero", MdDivu, 32'd100, 32'd0, 0, 1'b0, -1);
        check("divu_zero.const", alu_result, 32'hFFFF_FFFF);
        run_md("remu_zero", MdRemu, 32'd100, 32'd0, 0, 1'b0, -1);
        check("remu_zero.const", alu_result, 32'd100);
        run_md("mul_stall3", MdMul, 32'd7, 32'd9, 3, 1'b0, -1);
        check("mul_stall3.const", alu_result, 32'd63);

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_md("rnd_md", 2'($urandom), a, b, $urandom_range(0, 3), 1'($urandom), -1);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                rand_fields();
                md_valid = 0;
                run_alu("md_follow");
            end
        end

        run_md("rst_mid", MdDivu, $urandom, 32'd3, 0, 1'b0, 10);

        @(negedge clk);
        rand_fields();
        md_valid = 0;
        run_alu("post_rst_alu");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 Parameter BIT_W, default 32, datapath width.
REQ-002 Parameter MD_EN, default 1, enables the iterative multiply/divide unit; when 0, md_valid SHALL be ignored.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid / in_ready  input / output  1 / 1  issue handshake from ID/EX.
REQ-006 pc_in, rs1_dat, rs2_dat, imm  input  BIT_W each  operands.
REQ-007 alusrc, jal, jalr, branch, bne, branch_taken, compressed  input  1 each  control flags.
REQ-008 aluctrl  input  4  ALU op.
REQ-009 md_valid / md_op  input / input  1 / 2  md_op codes: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
REQ-010 rd_in, memrd_in, memwr_in, mem2reg_in, regwr_in  input  5/1/1/1/1  pass-through controls.
REQ-011 fwd_a_flag, fwd_a_dat, fwd_b_flag, fwd_b_dat  input  1/BIT_W/1/BIT_W  forwarding.
REQ-012 stall  input  1  downstream hold.
REQ-013 out_valid, alu_result, mem_wdata, pc_step  output  1/BIT_W/BIT_W/BIT_W  registered EX/MEM payload.
REQ-014 rd_out, memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out  output  5/1/1/1/1/1  registered controls.
REQ-015 redirect, redirect_pc, feedback_valid, busy  output  1/BIT_W/1/1  unregistered to fetch/predictor.

Function
REQ-016 Operands: rs1 = fwd_a_flag ? fwd_a_dat : rs1_dat; rs2 likewise with fwd_b; opA = (jal|branch) ? pc_in : rs1; opB = alusrc ? imm : rs2.
REQ-017 in_ready SHALL equal !stall && (FSM == IDLE); accept = in_valid && in_ready.
REQ-018 Non-MD accepted op: payload registered on the next edge, out_valid=1 (latency 1).
REQ-019 Cycles without accept and without MD completion, and !stall: out_valid=0, regwr_out=0, memwr_out=0, memrd_out=0, jump_out=0 (bubble).
REQ-020 stall=1: all registered outputs SHALL hold their values.
REQ-021 pc_step = pc_in + (compressed ? 2 : 4), modulo 2^BIT_W.
REQ-022 FSM states IDLE, BUSY, DONE; IDLE->BUSY on accept with md_valid&&MD_EN; BUSY->DONE after exactly BIT_W iteration cycles; DONE->IDLE on the first cycle with !stall, loading the MD result and latched controls into the payload with out_valid=1.
REQ-023 MD latency with no stall: out_valid rises BIT_W+2 edges after accept; busy=1 in BUSY and DONE.
REQ-024 MUL returns low BIT_W bits, MULHU high BIT_W bits of the unsigned 2*BIT_W product.
REQ-025 DIVU/REMU by zero: quotient all ones, remainder = dividend; no other flag raised.
REQ-026 rd/regwr and other controls of an MD op SHALL be latched at accept and emitted only at completion.
REQ-027 Branch eval, accept cycle only: taken = (rs1==rs2) XOR bne; feedback_valid = accept && branch.
REQ-028 redirect = accept && ((branch && taken != branch_taken) || jal || jalr).
REQ-029 redirect_pc = jalr ? {alu_out[BIT_W-1:1],0} : (branch && !taken) ? pc_step : alu_out.
REQ-030 redirect and feedback_valid SHALL be 0 whenever accept=0, including during BUSY/DONE.

Reset
REQ-031 rst_n low SHALL immediately force FSM=IDLE, all registered outputs to 0, MD iteration counter and partial results to 0.
REQ-032 Reset asserted mid-MD SHALL abandon the operation; no out_valid is produced for it after release.

Structure
REQ-033 Package ex_pkg SHALL hold the aluctrl encodings, md_op encodings and the FSM state enum.
REQ-034 Sub-module muldiv_iter SHALL implement shift-add multiply and restoring divide, one bit per cycle, with start/done ports.
REQ-035 ALU SHALL be instantiated from the existing alu block, unmodified.

Verification
REQ-036 ADD rs1=5, imm=7, alusrc=1, in_valid=1 -> next cycle out_valid=1, alu_result=12.
REQ-037 BEQ pc=0x100, rs1=rs2=3, imm=0x20, branch_taken=0 -> redirect=1, redirect_pc=0x120, feedback_valid=1 same cycle.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF (BIT_W=32) -> in_ready=0 for 33 cycles, then out_valid=1, alu_result=0xFFFFFFFE.
REQ-039 DIVU 100/0 and REMU 100/0 -> results 0xFFFFFFFF and 100.
REQ-040 stall=1 held 3 cycles while DONE -> payload unchanged, out_valid asserted once stall drops, exactly once.
REQ-041 rst_n pulsed low at BUSY cycle 10 -> outputs 0 immediately, in_ready=1 after release, no stray out_valid.
